// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback signal bundle around the issue scoreboard.
// Latency: n/a (wiring only).
// Backpressure: o_dec_ready toward decode, i_ex_ready from execute.
// Ports: slave = scoreboard side, master = decode/execute/writeback side.
interface issue_scoreboard_if #(
    parameter int REGNO     = 8,
    parameter int REGNO_LOG = 3,
    parameter int CTRL_W    = 64
);
    logic                 i_dec_submit;
    logic                 o_dec_ready;
    logic [CTRL_W-1:0]    i_ctrl;
    logic [REGNO_LOG-1:0] i_l_reg_sel;
    logic [REGNO_LOG-1:0] i_r_reg_sel;
    logic [1:0]           i_used_operands;
    logic [REGNO-1:0]     i_rf_ie;
    logic                 i_ex_ready;
    logic                 o_ex_submit;
    logic [CTRL_W-1:0]    o_ctrl;
    logic                 i_wb_valid;
    logic [REGNO_LOG-1:0] i_wb_reg;
    logic                 i_flush;
    logic [15:0]          o_stall_cnt;
    logic                 o_err;

    modport slave (
        input  i_dec_submit, i_ctrl, i_l_reg_sel, i_r_reg_sel, i_used_operands,
               i_rf_ie, i_ex_ready, i_wb_valid, i_wb_reg, i_flush,
        output o_dec_ready, o_ex_submit, o_ctrl, o_stall_cnt, o_err
    );

    modport master (
        output i_dec_submit, i_ctrl, i_l_reg_sel, i_r_reg_sel, i_used_operands,
               i_rf_ie, i_ex_ready, i_wb_valid, i_wb_reg, i_flush,
        input  o_dec_ready, o_ex_submit, o_ctrl, o_stall_cnt, o_err
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue stage: 2-entry bundle queue plus per-register pending-write counters.
// Latency: submit at t issues at t+1 via bypass when hazard-free and execute ready.
// Backpressure: o_dec_ready only when queue empty; hazarded head blocks all behind it.
// Ports: i_clk, i_rst (sync, active-high), bus (issue_scoreboard_if.slave).
module issue_scoreboard #(
    parameter int REGNO     = 8,
    parameter int REGNO_LOG = 3,
    parameter int CTRL_W    = 64,
    parameter int CNT_W     = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    issue_scoreboard_if.slave   bus
);
    typedef struct packed {
        logic [CTRL_W-1:0]    ctrl;
        logic [REGNO_LOG-1:0] l_sel;
        logic [REGNO_LOG-1:0] r_sel;
        logic [1:0]           used;
        logic [REGNO-1:0]     rf_ie;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    entry_t             q_q [2];
    entry_t             q_d [2];
    logic [1:0]         count_q, count_d;
    logic [CNT_W-1:0]   cnt_q [REGNO];
    logic [CNT_W-1:0]   cnt_d [REGNO];
    logic               ex_submit_q, ex_submit_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;

    entry_t             in_e, cand;
    logic               from_head, cand_vld, dst_sat, hazard, issue, pop, push, ovf;
    logic [REGNO-1:0]   inc_v, dec_v;

    always_comb begin
        in_e.ctrl  = bus.i_ctrl;
        in_e.l_sel = bus.i_l_reg_sel;
        in_e.r_sel = bus.i_r_reg_sel;
        in_e.used  = bus.i_used_operands;
        in_e.rf_ie = bus.i_rf_ie;

        from_head = (count_q != 2'd0);
        cand_vld  = from_head | bus.i_dec_submit;
        cand      = from_head ? q_q[0] : in_e;

        // A saturated destination counter could not record another write.
        dst_sat = 1'b0;
        for (int r = 0; r < REGNO; r++) begin
            if (cand.rf_ie[r] && (cnt_q[r] == CNT_MAX)) dst_sat = 1'b1;
        end
        hazard = (cand.used[0] && (cnt_q[cand.l_sel] != '0))
               | (cand.used[1] && (cnt_q[cand.r_sel] != '0))
               | dst_sat;

        issue = cand_vld & bus.i_ex_ready & ~hazard & ~bus.i_flush;
        pop   = issue & from_head;
        ovf   = bus.i_dec_submit & ~bus.i_flush & (count_q == 2'd2);
        // A submit is queued unless the bypass consumed it or there is no room.
        push  = bus.i_dec_submit & ~bus.i_flush & ~(issue & ~from_head) & (count_q != 2'd2);

        q_d     = q_q;
        count_d = count_q;
        if (bus.i_flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                q_d[0]  = q_q[1];
                count_d = count_q - 2'd1;
            end
            if (push) begin
                q_d[count_d[0]] = in_e;
                count_d         = count_d + 2'd1;
            end
        end

        err_d = err_q | ovf;
        for (int r = 0; r < REGNO; r++) begin
            inc_v[r] = issue & cand.rf_ie[r];
            dec_v[r] = bus.i_wb_valid & (bus.i_wb_reg == REGNO_LOG'(r));
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r]) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end

        ex_submit_d = issue;
        ctrl_d      = issue ? cand.ctrl : ctrl_q;

        stall_cnt_d = stall_cnt_q;
        if (cand_vld && bus.i_ex_ready && hazard && !bus.i_flush && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) q_q[i] <= '0;
            for (int r = 0; r < REGNO; r++) cnt_q[r] <= '0;
            count_q     <= 2'd0;
            ex_submit_q <= 1'b0;
            ctrl_q      <= '0;
            stall_cnt_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            ex_submit_q <= ex_submit_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_dec_ready = (count_q == 2'd0);
    assign bus.o_ex_submit = ex_submit_q;
    assign bus.o_ctrl      = ctrl_q;
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic against a queue model.
// Latency: one check set per clock, sampled 1 time unit after the rising edge.
// Backpressure: random decode only submits when ready was seen the cycle before.
module tb_issue_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scoreboard_if #(.REGNO(8), .REGNO_LOG(3), .CTRL_W(64)) bus();
    issue_scoreboard #(.REGNO(8), .REGNO_LOG(3), .CTRL_W(64), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    typedef struct {
        logic [63:0] ctrl;
        int          l;
        int          r;
        logic [1:0]  used;
        int          dst;
    } bun_t;

    bun_t        mq[$];
    int          mcnt[8];
    bit          m_sub;
    logic [63:0] m_ctrl;
    int          m_stall;
    bit          m_err;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int dst_of(input logic [7:0] ie);
        int d = -1;
        for (int i = 0; i < 8; i++) if (ie[i]) d = i;
        return d;
    endfunction

    task automatic idle();
        bus.i_dec_submit = 0; bus.i_ctrl = '0; bus.i_l_reg_sel = '0; bus.i_r_reg_sel = '0;
        bus.i_used_operands = '0; bus.i_rf_ie = '0; bus.i_wb_valid = 0; bus.i_wb_reg = '0;
        bus.i_flush = 0;
    endtask

    task automatic sub(input logic [63:0] c, input int l, input int r,
                       input logic [1:0] u, input logic [7:0] ie);
        bus.i_dec_submit = 1; bus.i_ctrl = c; bus.i_l_reg_sel = 3'(l);
        bus.i_r_reg_sel = 3'(r); bus.i_used_operands = u; bus.i_rf_ie = ie;
    endtask

    task automatic wb(input int reg_n);
        bus.i_wb_valid = 1; bus.i_wb_reg = 3'(reg_n);
    endtask

    // Advance one clock: model the edge from the current inputs, then compare.
    task automatic step();
        bun_t inb, cand;
        bit   have, bypass, hz, fire;
        int   pre_sz, w;
        inb.ctrl = bus.i_ctrl; inb.l = int'(bus.i_l_reg_sel); inb.r = int'(bus.i_r_reg_sel);
        inb.used = bus.i_used_operands; inb.dst = dst_of(bus.i_rf_ie);
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            m_sub = 0; m_ctrl = '0; m_stall = 0; m_err = 0;
        end else begin
            pre_sz = mq.size();
            have = 0; bypass = 0;
            if (pre_sz > 0) begin cand = mq[0]; have = 1; end
            else if (bus.i_dec_submit) begin cand = inb; have = 1; bypass = 1; end
            hz = have && ((cand.used[0] && mcnt[cand.l] > 0) || (cand.used[1] && mcnt[cand.r] > 0)
                          || (cand.dst >= 0 && mcnt[cand.dst] == 3));
            fire = have && bus.i_ex_ready && !hz && !bus.i_flush;
            if (have && bus.i_ex_ready && hz && !bus.i_flush && m_stall < 65535) m_stall++;
            m_sub = fire;
            if (fire) m_ctrl = cand.ctrl;
            if (fire && cand.dst >= 0) mcnt[cand.dst]++;
            if (bus.i_wb_valid) begin
                w = int'(bus.i_wb_reg);
                mcnt[w]--;
                if (mcnt[w] < 0) begin mcnt[w] = 0; m_err = 1; end
            end
            if (bus.i_flush) mq.delete();
            else begin
                if (fire && !bypass) void'(mq.pop_front());
                if (bus.i_dec_submit && !(fire && bypass)) begin
                    if (pre_sz == 2) m_err = 1;
                    else mq.push_back(inb);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("ex_submit", 64'(bus.o_ex_submit), 64'(m_sub));
        chk("ctrl", bus.o_ctrl, m_ctrl);
        chk("dec_ready", 64'(bus.o_dec_ready), 64'(mq.size() == 0));
        chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(m_stall));
        chk("err", 64'(bus.o_err), 64'(m_err));
    endtask

    initial begin
        bit rdy_prev, rdy_now;
        int pend[$];
        idle();
        bus.i_ex_ready = 1;
        rst = 1;
        step(); step();
        chk("rst_submit", 64'(bus.o_ex_submit), 64'd0);
        chk("rst_ctrl", bus.o_ctrl, 64'd0);
        chk("rst_ready", 64'(bus.o_dec_ready), 64'd1);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        rst = 0;

        // Bypass issue of a write to r2.
        sub(64'h1111, 0, 0, 2'b00, 8'h04); step();
        chk("byp_submit", 64'(bus.o_ex_submit), 64'd1);
        chk("byp_ctrl", bus.o_ctrl, 64'h1111);
        chk("byp_ready", 64'(bus.o_dec_ready), 64'd1);

        // RAW hazard on r3, released two cycles after the retire.
        sub(64'h2222, 0, 0, 2'b00, 8'h08); step();
        sub(64'h3333, 3, 0, 2'b01, 8'h00); step();
        chk("raw_held", 64'(bus.o_ex_submit), 64'd0);
        chk("raw_stall", 64'(bus.o_stall_cnt), 64'd1);
        chk("raw_ready", 64'(bus.o_dec_ready), 64'd0);
        idle(); step();
        wb(3); step();
        chk("raw_wb_nofwd", 64'(bus.o_ex_submit), 64'd0);
        idle(); step();
        chk("raw_release", 64'(bus.o_ex_submit), 64'd1);
        chk("raw_ctrl", bus.o_ctrl, 64'h3333);

        // Fill both entries while execute is busy, then drain in order.
        bus.i_ex_ready = 0;
        sub(64'hA0, 0, 0, 2'b00, 8'h00); step();
        sub(64'hB0, 0, 0, 2'b00, 8'h00); step();
        chk("full_ready", 64'(bus.o_dec_ready), 64'd0);
        idle(); bus.i_ex_ready = 1; step();
        chk("drain_a", bus.o_ctrl, 64'hA0);
        step();
        chk("drain_b", bus.o_ctrl, 64'hB0);
        chk("drain_b_vld", 64'(bus.o_ex_submit), 64'd1);

        // Saturate r1, fourth write waits for one retire.
        for (int i = 0; i < 3; i++) begin sub(64'hC0 + 64'(i), 0, 0, 2'b00, 8'h02); step(); end
        sub(64'hC3, 0, 0, 2'b00, 8'h02); step();
        chk("sat_held", 64'(bus.o_ex_submit), 64'd0);
        idle(); step();
        wb(1); step();
        chk("sat_wb_cycle", 64'(bus.o_ex_submit), 64'd0);
        idle(); step();
        chk("sat_release", 64'(bus.o_ctrl), 64'hC3);

        // Flush a full queue while retiring r5's only pending write.
        sub(64'hD0, 0, 0, 2'b00, 8'h20); step();
        bus.i_ex_ready = 0;
        sub(64'hD1, 0, 0, 2'b00, 8'h00); step();
        sub(64'hD2, 0, 0, 2'b00, 8'h00); step();
        idle(); bus.i_flush = 1; wb(5); step();
        chk("flush_noissue", 64'(bus.o_ex_submit), 64'd0);
        chk("flush_ready", 64'(bus.o_dec_ready), 64'd1);
        idle(); bus.i_ex_ready = 1;
        sub(64'hD5, 5, 5, 2'b11, 8'h00); step();
        chk("flush_r5_free", 64'(bus.o_ex_submit), 64'd1);
        chk("flush_err", 64'(bus.o_err), 64'd0);

        // Retire of an idle register sets a sticky error; reset mid-stall.
        idle(); wb(5); step();
        chk("err_set", 64'(bus.o_err), 64'd1);
        idle(); step(); step();
        chk("err_sticky", 64'(bus.o_err), 64'd1);
        sub(64'hE0, 0, 0, 2'b00, 8'h40); step();
        sub(64'hE1, 0, 6, 2'b10, 8'h00); step();
        idle(); step();
        rst = 1; step();
        chk("mid_rst_submit", 64'(bus.o_ex_submit), 64'd0);
        chk("mid_rst_ctrl", bus.o_ctrl, 64'd0);
        chk("mid_rst_stall", 64'(bus.o_stall_cnt), 64'd0);
        chk("mid_rst_err", 64'(bus.o_err), 64'd0);
        chk("mid_rst_ready", 64'(bus.o_dec_ready), 64'd1);
        rst = 0;

        // Random traffic, decode honouring the one-cycle-late ready.
        rdy_prev = 1;
        for (int c = 0; c < 800; c++) begin
            idle();
            if (rdy_prev && $urandom_range(0, 9) < 6) begin
                sub({$urandom, $urandom}, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00);
            end
            bus.i_ex_ready = ($urandom_range(0, 3) != 0);
            bus.i_flush    = ($urandom_range(0, 39) == 0);
            pend.delete();
            for (int i = 0; i < 8; i++) if (mcnt[i] > 0) pend.push_back(i);
            if (pend.size() > 0 && $urandom_range(0, 9) < 4)
                wb(pend[$urandom_range(0, pend.size() - 1)]);
            rdy_now = (mq.size() == 0);
            step();
            rdy_prev = rdy_now;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Sits between decode and execute.
- Buffers decoded control bundles in a 2-entry queue and tracks in-flight register writes with per-register pending counters.
- Issues a bundle to execute only when its source operands have no pending writes.
- Turns decode's one-cycle-delayed ready/submit handshake into hazard-safe, in-order issue.

Parameters:
REGNO, 8, number of architectural registers
REGNO_LOG, 3, register select width
CTRL_W, 64, width of the opaque control bundle carried from decode to execute
CNT_W, 2, pending-write counter width per register (saturates at 2^CNT_W-1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_dec_submit  in  1  decode output valid pulse
o_dec_ready  out  1  ready to decode (combinational)
i_ctrl  in  CTRL_W  opaque control bundle, captured with i_dec_submit
i_l_reg_sel  in  REGNO_LOG  left operand register
i_r_reg_sel  in  REGNO_LOG  right operand register
i_used_operands  in  2  bit0 = left used, bit1 = right used
i_rf_ie  in  REGNO  destination write enable, one-hot or zero
i_ex_ready  in  1  execute can accept an issue this cycle
o_ex_submit  out  1  registered issue pulse to execute
o_ctrl  out  CTRL_W  registered bundle issued with o_ex_submit
i_wb_valid  in  1  one pending write retired
i_wb_reg  in  REGNO_LOG  register retired
i_flush  in  1  discard all queued, not-yet-issued bundles
o_stall_cnt  out  16  saturating count of hazard-stall cycles
o_err  out  1  sticky: retire of a register with zero pending count

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk, all state on its rising edge. Reset values: queue empty, all counters 0, o_ex_submit 0, o_ctrl 0, o_stall_cnt 0, o_err 0.
- Queue: 2 entries, in order. Each entry holds {ctrl, l_sel, r_sel, used_operands, rf_ie}.
- o_dec_ready = (count == 0). Decode samples ready one cycle before it submits, so 2 entries absorb the worst case and the queue never overflows. A submit with count == 2 is a protocol violation: drop it and set o_err.
- Candidate selection: the head entry if count > 0; otherwise the incoming bundle when i_dec_submit (bypass path).
- hazard = (used[0] & cnt[l_sel] != 0) | (used[1] & cnt[r_sel] != 0) | (rf_ie targets a register whose cnt is saturated).
  - Counters are evaluated at current-cycle values, before this cycle's inc/dec.
  - A retire in cycle t unblocks a dependent no earlier than t+1; there is no same-cycle wb forwarding.
- Issue fires when a candidate exists, i_ex_ready, ~hazard and ~i_flush. Next cycle: o_ex_submit = 1 and o_ctrl = candidate ctrl.
  - Otherwise o_ex_submit = 0 and o_ctrl holds its last value.
  - Bypass latency: submit at t, o_ex_submit at t+1.
- On issue, the counter selected by rf_ie increments.
- On i_wb_valid, cnt[i_wb_reg] decrements.
  - Increment and decrement of the same register in one cycle leaves it unchanged.
  - A decrement of a zero counter leaves it at 0 and sets o_err.
- Queue update on the same edge:
  - Head pops on issue from head.
  - A submit not consumed by bypass pushes to the tail.
  - Push and pop together keep count unchanged.
- i_flush: queue emptied and that cycle's issue and push suppressed, so o_ex_submit = 0 next cycle.
  - Counters are NOT cleared. Execute reports every issued writing bundle exactly once via i_wb_valid, squashed or not.
  - Retires in the flush cycle still apply.
- o_stall_cnt increments when a candidate exists & i_ex_ready & hazard & ~i_flush. It saturates at 16'hFFFF.
- Strict in-order issue: a hazarded head blocks everything behind it.

Test Plan:
- Reset then submit a bundle with no operands and rf_ie = 8'h04, ex_ready = 1 at t -> o_ex_submit = 1 at t+1, o_ctrl matches, cnt[2] = 1, o_dec_ready stays 1.
- Issue a write to r3; next cycle submit with used = 01, l_sel = 3 -> held with stall_cnt incrementing. Assert i_wb_valid with wb_reg = 3 at cycle w -> o_ex_submit at w+2.
- Hold i_ex_ready = 0 and submit on two consecutive cycles -> count = 2, o_dec_ready = 0. Release ready -> two issues in order on consecutive cycles.
- Issue three writes to r1 with no retire -> cnt[1] = 3. A fourth write to r1 stalls until one i_wb_valid with wb_reg = 1.
- Queue holding 2 entries, i_flush plus simultaneous i_wb_valid for r5 (cnt = 1) -> queue empty, no issue, cnt[5] = 0, o_dec_ready = 1 next cycle.
- i_wb_valid for a register with cnt = 0 -> o_err = 1 and stays set until reset; assert i_rst mid-stall -> all outputs at reset values next cycle.
